// File: rtl/tm_pwm_pkg.sv
// rtl/tm_pwm_pkg.sv - Shared register map, blocker states and reset constants for tm_pwm_timer
package tm_pwm_pkg;

    localparam logic [3:0] REG_US0  = 4'h0;
    localparam logic [3:0] REG_US1  = 4'h1;
    localparam logic [3:0] REG_US2  = 4'h2;
    localparam logic [3:0] REG_US3  = 4'h3;
    localparam logic [3:0] REG_MS0  = 4'h4;
    localparam logic [3:0] REG_MS1  = 4'h5;
    localparam logic [3:0] REG_MS2  = 4'h6;
    localparam logic [3:0] REG_MS3  = 4'h7;
    localparam logic [3:0] REG_SEL  = 4'h8;
    localparam logic [3:0] REG_DUTY = 4'h9;
    localparam logic [3:0] REG_ENA  = 4'hA;
    localparam logic [3:0] REG_POL  = 4'hB;
    localparam logic [3:0] REG_CAR  = 4'hC;
    localparam logic [3:0] REG_BLKL = 4'hD;
    localparam logic [3:0] REG_BLKH = 4'hE;
    localparam logic [3:0] REG_ID   = 4'hF;

    localparam logic [7:0] PRESC_RST = 8'd3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DELAY = 1'b1
    } blk_state_t;

    // Pick byte idx (0 = LSB) out of a 32-bit word
    function automatic logic [7:0] byte_of(input logic [31:0] word, input logic [1:0] idx);
        logic [31:0] shifted;
        shifted = word >> {idx, 3'b000};
        return shifted[7:0];
    endfunction

endpackage

// File: rtl/tm_pwm_channel.sv
// rtl/tm_pwm_channel.sv - One PWM channel: shadowed duty, period-boundary load, comparator and polarity
module tm_pwm_channel
    import tm_pwm_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       load,
    input  logic [7:0] pwm_cnt,
    input  logic       pol,
    output logic [7:0] shadow,
    output logic       pwm
);

    logic [7:0] active;

    // Bus writes land in the shadow; the active duty only changes at the period boundary
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow <= '0;
            active <= '0;
        end else begin
            if (wr_en) begin
                shadow <= wr_data;
            end
            if (load) begin
                active <= shadow;
            end
        end
    end

    assign pwm = (pwm_cnt < active) ^ pol;

endmodule

// File: rtl/tm_pwm_timer.sv
// rtl/tm_pwm_timer.sv - WISHBONE timer/PWM slave; define TMPWM_CENTER_ALIGNED_EN for center-aligned PWM
module tm_pwm_timer
    import tm_pwm_pkg::*;
#(
    parameter int CNT_PRESC = 24,
    parameter int N_PWM     = 6,
    parameter int ENA_TMR   = 1
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic [3:0]       wb_adr_i,
    input  logic [7:0]       wb_dat_i,
    output logic [7:0]       wb_dat_o,
    input  logic             wb_we_i,
    input  logic             wb_stb_i,
    output logic             wb_ack_o,
    output logic [N_PWM-1:0] pwm_o,
    output logic [N_PWM-1:0] pwm_e_o
);

    localparam int   PW     = $clog2(CNT_PRESC);
    localparam logic TMR_ON = (ENA_TMR != 0);

    logic [PW-1:0]          presc;
    logic                   tick;
    logic [31:0]            cnt_us;
    logic [31:0]            cnt_ms;
    logic [31:0]            latch;
    logic [9:0]             cnt_us2;
    logic [2:0]             sel;
    logic [N_PWM-1:0]       ena;
    logic [N_PWM-1:0]       pol;
    logic [7:0]             car;
    logic [7:0]             pwm_pre;
    logic [7:0]             pwm_cnt;
    logic                   pwm_dir_down;
    logic                   pwm_step;
    logic                   pwm_load;
    logic [7:0]             blk_lo;
    blk_state_t             state;
    blk_state_t             state_nxt;
    logic [15:0]            cnt_blk;
    logic [PW-1:0]          pre_bk;
    logic                   rd;
    logic                   wr;
    logic                   blk_we;
    logic [N_PWM-1:0][7:0]  shadow;
    logic [N_PWM-1:0]       duty_we;
    logic [7:0]             duty_rd;

    assign rd     = wb_stb_i & ~wb_we_i;
    assign wr     = wb_stb_i & wb_we_i;
    assign blk_we = wr & (wb_adr_i == REG_BLKH) & TMR_ON;
    assign tick   = (presc == PW'(CNT_PRESC - 1));

`ifdef TMPWM_CENTER_ALIGNED_EN
    logic center;

    // Center-aligned mode bit lives in bit 7 of the channel-select register
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            center <= 1'b0;
        end else if (wr && wb_adr_i == REG_SEL) begin
            center <= wb_dat_i[7];
        end
    end
`else
    logic center;
    assign center = 1'b0;
`endif

    // µs prescaler always runs: the PWM carrier depends on it even without the timer
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // µs and ms counters, held at zero when the timer is compiled out
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || !TMR_ON) begin
            cnt_us  <= '0;
            cnt_us2 <= '0;
            cnt_ms  <= '0;
        end else if (tick) begin
            cnt_us <= cnt_us + 1'b1;
            if (cnt_us2 == 10'd999) begin
                cnt_us2 <= '0;
                cnt_ms  <= cnt_ms + 1'b1;
            end else begin
                cnt_us2 <= cnt_us2 + 1'b1;
            end
        end
    end

    // Reading byte 0 snapshots the whole counter so bytes 1..3 stay coherent
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || !TMR_ON) begin
            latch <= '0;
        end else if (rd && wb_adr_i == REG_US0) begin
            latch <= cnt_us;
        end else if (rd && wb_adr_i == REG_MS0) begin
            latch <= cnt_ms;
        end
    end

    // Control registers written from the bus
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            sel    <= '0;
            ena    <= '0;
            pol    <= '0;
            car    <= PRESC_RST;
            blk_lo <= '0;
        end else if (wr) begin
            case (wb_adr_i)
                REG_SEL:  sel    <= wb_dat_i[2:0];
                REG_ENA:  ena    <= wb_dat_i[N_PWM-1:0];
                REG_POL:  pol    <= wb_dat_i[N_PWM-1:0];
                REG_CAR:  car    <= wb_dat_i;
                REG_BLKL: blk_lo <= wb_dat_i;
                default:  ;
            endcase
        end
    end

    // The channel counter steps once every car+1 µs ticks
    assign pwm_step = tick && (pwm_pre >= car);
    // Duty transfer on the step that brings the counter back to 0
    assign pwm_load = pwm_step &&
                      (center ? (pwm_dir_down && pwm_cnt == 8'd1) : (pwm_cnt == 8'hFF));

    // Carrier prescaler and shared PWM counter (up-only, or up/down when centered)
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            pwm_pre      <= '0;
            pwm_cnt      <= '0;
            pwm_dir_down <= 1'b0;
        end else if (tick) begin
            if (pwm_pre >= car) begin
                pwm_pre <= '0;
                if (!center) begin
                    pwm_cnt      <= pwm_cnt + 1'b1;
                    pwm_dir_down <= 1'b0;
                end else if (!pwm_dir_down) begin
                    if (pwm_cnt == 8'hFF) begin
                        pwm_dir_down <= 1'b1;
                        pwm_cnt      <= 8'hFE;
                    end else begin
                        pwm_cnt <= pwm_cnt + 1'b1;
                    end
                end else begin
                    pwm_cnt <= pwm_cnt - 1'b1;
                    if (pwm_cnt == 8'd1) begin
                        pwm_dir_down <= 1'b0;
                    end
                end
            end else begin
                pwm_pre <= pwm_pre + 1'b1;
            end
        end
    end

    // Route duty writes/reads to the selected channel; out-of-range selects hit nothing
    always_comb begin
        duty_rd = 8'h00;
        duty_we = '0;
        for (int i = 0; i < N_PWM; i++) begin
            if (sel == 3'(i)) begin
                duty_rd    = shadow[i];
                duty_we[i] = wr && (wb_adr_i == REG_DUTY);
            end
        end
    end

    for (genvar g = 0; g < N_PWM; g++) begin : g_ch
        tm_pwm_channel u_ch (
            .clk     (wb_clk_i),
            .rst     (wb_rst_i),
            .wr_en   (duty_we[g]),
            .wr_data (wb_dat_i),
            .load    (pwm_load),
            .pwm_cnt (pwm_cnt),
            .pol     (pol[g]),
            .shadow  (shadow[g]),
            .pwm     (pwm_o[g])
        );
    end

    assign pwm_e_o = ena;

    // Blocker state register, delay counter and its µs sub-prescaler
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state   <= ST_IDLE;
            cnt_blk <= '0;
            pre_bk  <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE) begin
                if (blk_we) begin
                    cnt_blk <= {wb_dat_i, blk_lo};
                    pre_bk  <= PW'(CNT_PRESC - 1);
                end
            end else begin
                if (pre_bk == '0) begin
                    pre_bk <= PW'(CNT_PRESC - 1);
                    if (cnt_blk != 16'd0) begin
                        cnt_blk <= cnt_blk - 1'b1;
                    end
                end else begin
                    pre_bk <= pre_bk - 1'b1;
                end
            end
        end
    end

    // Blocker next state and bus acknowledge; a blocker write is held until the delay expires
    always_comb begin
        state_nxt = state;
        wb_ack_o  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (blk_we) begin
                    state_nxt = ST_DELAY;
                end
            end
            ST_DELAY: begin
                if (!wb_stb_i || cnt_blk == 16'd0) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (!wb_rst_i && wb_stb_i) begin
            wb_ack_o = !blk_we || (state == ST_DELAY && cnt_blk == 16'd0);
        end
    end

    // Combinational read mux
    always_comb begin
        wb_dat_o = 8'h00;
        case (wb_adr_i)
            REG_US0:  wb_dat_o = cnt_us[7:0];
            REG_MS0:  wb_dat_o = cnt_ms[7:0];
            REG_US1, REG_US2, REG_US3,
            REG_MS1, REG_MS2, REG_MS3:
                      wb_dat_o = byte_of(latch, wb_adr_i[1:0]);
            REG_SEL:  wb_dat_o = {center, 4'b0000, sel};
            REG_DUTY: wb_dat_o = duty_rd;
            REG_ENA:  wb_dat_o = 8'(ena);
            REG_POL:  wb_dat_o = 8'(pol);
            REG_CAR:  wb_dat_o = car;
            REG_BLKL: wb_dat_o = blk_lo;
            REG_ID:   wb_dat_o = {4'(N_PWM), 3'b000, state == ST_DELAY};
            default:  wb_dat_o = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_tm_pwm_timer.sv
// tb/tb_tm_pwm_timer.sv - Directed self-checking bench for tm_pwm_timer
module tb_tm_pwm_timer;

    logic       clk;
    logic       rst;
    logic [3:0] adr;
    logic [7:0] dat;
    logic       we;
    logic       stb;
    logic [7:0] dat_o;
    logic       ack;
    logic [5:0] pwm;
    logic [5:0] pwm_e;
    logic [7:0] dat_o0;
    logic       ack0;
    logic [1:0] pwm0;
    logic [1:0] pwm_e0;

    int n_asserts = 0;
    int n_fail    = 0;

    logic [7:0] rdat;
    logic [7:0] rdat0;
    logic       last_ack;
    logic       last_ack0;
    int         n;
    int         hi_a;
    int         hi_b;
    int         lo;
    int         waited;

    tm_pwm_timer #(
        .CNT_PRESC (24),
        .N_PWM     (6),
        .ENA_TMR   (1)
    ) u_dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .wb_adr_i (adr),
        .wb_dat_i (dat),
        .wb_dat_o (dat_o),
        .wb_we_i  (we),
        .wb_stb_i (stb),
        .wb_ack_o (ack),
        .pwm_o    (pwm),
        .pwm_e_o  (pwm_e)
    );

    tm_pwm_timer #(
        .CNT_PRESC (24),
        .N_PWM     (2),
        .ENA_TMR   (0)
    ) u_dut0 (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .wb_adr_i (adr),
        .wb_dat_i (dat),
        .wb_dat_o (dat_o0),
        .wb_we_i  (we),
        .wb_stb_i (stb),
        .wb_ack_o (ack0),
        .pwm_o    (pwm0),
        .pwm_e_o  (pwm_e0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        stb = 1'b0;
        we  = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a);
        adr = a;
        we  = 1'b0;
        stb = 1'b1;
        @(negedge clk);
        rdat     = dat_o;
        rdat0    = dat_o0;
        last_ack = ack;
        @(posedge clk);
        #1;
        stb = 1'b0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        adr = a;
        dat = d;
        we  = 1'b1;
        stb = 1'b1;
        @(negedge clk);
        last_ack = ack;
        @(posedge clk);
        #1;
        stb = 1'b0;
        we  = 1'b0;
    endtask

    task automatic blk_run(input logic [7:0] hi, output int cycles);
        adr = 4'hE;
        dat = hi;
        we  = 1'b1;
        stb = 1'b1;
        cycles = 0;
        forever begin
            @(negedge clk);
            if (cycles == 0) last_ack0 = ack0;
            if (ack || cycles >= 1000) break;
            @(posedge clk);
            #1;
            cycles++;
        end
        @(posedge clk);
        #1;
        stb = 1'b0;
        we  = 1'b0;
    endtask

    task automatic count_run(input logic v, input int max, output int cnt);
        cnt = 0;
        while (pwm[2] === v && cnt < max) begin
            cnt++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_rise(output int w);
        logic prev;
        prev = pwm[2];
        w = 0;
        while (w < 20000) begin
            @(posedge clk);
            #1;
            w++;
            if (pwm[2] === 1'b1 && prev === 1'b0) break;
            prev = pwm[2];
        end
    endtask

    initial begin
        rst = 1'b0;
        adr = 4'h0;
        dat = 8'h00;
        we  = 1'b0;
        stb = 1'b0;

        // Reset state
        do_reset();
        check("rst_ack", ack, 1'b0);
        check("rst_pwm_e", pwm_e, 6'h00);
        check("rst_pwm", pwm, 6'h00);
        rd(4'hC);
        check("rst_car", rdat, 8'h03);
        check("rd_ack", last_ack, 1'b1);
        rd(4'hF);
        check("rst_id", rdat, 8'h60);
        rd(4'h8);
        check("rst_sel", rdat, 8'h00);
        rd(4'h9);
        check("rst_duty", rdat, 8'h00);
        wr(4'h3, 8'hAA);
        check("ro_wr_ack", last_ack, 1'b1);
        rd(4'h3);
        check("ro_wr_ignored", rdat, 8'h00);
        wr(4'hF, 8'h00);
        rd(4'hF);
        check("id_wr_ignored", rdat, 8'h60);

        // µs / ms counters
        do_reset();
        repeat (73) @(posedge clk);
        #1;
        rd(4'h0);
        check("us_b0", rdat, 8'h03);
        check("tmr_off_us_b0", rdat0, 8'h00);
        rd(4'h1);
        check("us_b1", rdat, 8'h00);
        rd(4'h2);
        check("us_b2", rdat, 8'h00);
        rd(4'h3);
        check("us_b3", rdat, 8'h00);
        repeat (23922) @(posedge clk);
        #1;
        rd(4'h4);
        check("ms_before", rdat, 8'h00);
        rd(4'h4);
        check("ms_after", rdat, 8'h01);
        check("tmr_off_ms_b0", rdat0, 8'h00);
        rd(4'h5);
        check("ms_b1", rdat, 8'h00);
        rd(4'h0);
        check("us_1000_b0", rdat, 8'hE8);
        rd(4'h1);
        check("us_1000_b1", rdat, 8'h03);
        check("tmr_off_latch", rdat0, 8'h00);

        // Coherent latch across the 0xFF -> 0x100 carry
        do_reset();
        repeat (6143) @(posedge clk);
        #1;
        rd(4'h0);
        check("coh_b0", rdat, 8'hFF);
        rd(4'h1);
        check("coh_b1", rdat, 8'h00);
        rd(4'h2);
        check("coh_b2", rdat, 8'h00);
        rd(4'h0);
        check("live_b0", rdat, 8'h00);
        rd(4'h1);
        check("live_b1", rdat, 8'h01);

        // PWM
        do_reset();
        wr(4'hC, 8'h00);
        wr(4'h8, 8'h82);
        rd(4'h8);
`ifdef TMPWM_CENTER_ALIGNED_EN
        check("sel_bit7", rdat, 8'h82);
`else
        check("sel_bit7", rdat, 8'h02);
`endif
        wr(4'h8, 8'h07);
        wr(4'h9, 8'h55);
        rd(4'h9);
        check("duty_sel_oob", rdat, 8'h00);
        wr(4'h8, 8'h02);
        rd(4'h9);
        check("duty_oob_no_write", rdat, 8'h00);
        wr(4'h9, 8'h40);
        rd(4'h9);
        check("duty_shadow", rdat, 8'h40);
        wr(4'hA, 8'h04);
        check("pwm_e", pwm_e, 6'h04);
        check("tmr_off_pwm_e", pwm_e0, 2'b00);
        wait_rise(waited);
        check("pwm_rise_seen", waited < 20000, 1'b1);
        count_run(1'b1, 700, hi_a);
        wr(4'h9, 8'h80);
        count_run(1'b1, 10000, hi_b);
        check("pwm_hi_64", hi_a + 1 + hi_b, 1536);
        count_run(1'b0, 10000, lo);
        check("pwm_lo_64", lo, 4608);
        count_run(1'b1, 10000, hi_a);
        check("pwm_hi_128", hi_a, 3072);
        wr(4'h9, 8'h00);
        rd(4'h9);
        check("duty_zero_rd", rdat, 8'h00);
        count_run(1'b0, 7000, lo);
        check("pwm_duty0_low", lo, 7000);
        wr(4'hB, 8'h04);
        count_run(1'b1, 7000, hi_a);
        check("pwm_pol_high", hi_a, 7000);
        check("pwm_vec", pwm, 6'b000100);
        check("tmr_off_pwm", pwm0, 2'b00);

        // Blocker
        do_reset();
        wr(4'hD, 8'h02);
        blk_run(8'h00, n);
        check("blk_n2_latency", n, 49);
        check("tmr_off_blk_ack", last_ack0, 1'b1);
        wr(4'hD, 8'h00);
        blk_run(8'h00, n);
        check("blk_n0_latency", n, 1);
        adr = 4'hE;
        dat = 8'h01;
        we  = 1'b1;
        stb = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        @(negedge clk);
        check("blk_hold_ack", ack, 1'b0);
        @(posedge clk);
        #1;
        adr = 4'hF;
        we  = 1'b0;
        @(negedge clk);
        check("blk_status_busy", dat_o, 8'h61);
        check("blk_status_ack", ack, 1'b1);
        @(posedge clk);
        #1;
        stb = 1'b0;
        @(posedge clk);
        #1;
        rd(4'hF);
        check("blk_abort_idle", rdat, 8'h60);

        // Reset during DELAY
        do_reset();
        wr(4'hA, 8'h3F);
        check("pwm_e_all", pwm_e, 6'h3F);
        wr(4'hC, 8'h10);
        wr(4'hD, 8'h05);
        adr = 4'hE;
        dat = 8'h00;
        we  = 1'b1;
        stb = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("rst_delay_ack", ack, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        stb = 1'b0;
        we  = 1'b0;
        check("rst_delay_pwm_e", pwm_e, 6'h00);
        rd(4'hF);
        check("rst_delay_idle", rdat, 8'h60);
        rd(4'hC);
        check("rst_delay_car", rdat, 8'h03);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
